// File: rtl/mdu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdu
// Brief    : Multi-cycle multiply/divide unit (shift-add multiply and restoring
//            divide, one bit per cycle). Optional macro MDU_FAST_MUL_EN turns
//            MULT/MULTU into a single-cycle '*' operation.
// Revision : 1.0  initial release
// ============================================================================
module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  MDUOp,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Zero,
  output logic        DivZero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [5:0]  r_cnt;
  logic        r_is_div, r_neg, r_neg_rem, r_done;

  // Signed ops run on magnitudes; the result signs are restored in FIN
  logic        w_sa, w_sb, w_fast_start, w_fast_fin;
  logic [31:0] w_mag_a, w_mag_b;
  assign w_sa    = ~MDUOp[0] & A[31];
  assign w_sb    = ~MDUOp[0] & B[31];
  assign w_mag_a = w_sa ? -A : A;
  assign w_mag_b = w_sb ? -B : B;

  logic [32:0] w_sum, w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 33'd0);
  assign w_shift = {r_hi, r_lo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_sub   = w_shift[31:0] - r_b;

  logic [63:0] w_prod_mag, w_prod;
  logic [31:0] w_quot, w_rem, w_raw_a;
`ifdef MDU_FAST_MUL_EN
  assign w_fast_start = ~MDUOp[1];
  assign w_fast_fin   = ~r_is_div;
  assign w_prod_mag   = w_fast_fin ? ({32'd0, r_a} * {32'd0, r_b}) : {r_hi, r_lo};
`else
  assign w_fast_start = 1'b0;
  assign w_fast_fin   = 1'b0;
  assign w_prod_mag   = {r_hi, r_lo};
`endif
  assign w_prod  = r_neg ? -w_prod_mag : w_prod_mag;
  assign w_quot  = r_neg ? -r_lo : r_lo;
  assign w_rem   = r_neg_rem ? -r_hi : r_hi;
  assign w_raw_a = r_neg_rem ? -r_a : r_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_fast_start ? S_FIN : S_CALC;
      S_CALC:  if (r_cnt == 6'd31) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_cnt     <= 6'd0;
      r_is_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_done    <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
      DivZero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_a       <= w_mag_a;
          r_b       <= w_mag_b;
          r_hi      <= 32'd0;
          r_lo      <= MDUOp[1] ? w_mag_a : w_mag_b;
          r_cnt     <= 6'd0;
          r_is_div  <= MDUOp[1];
          r_neg     <= w_sa ^ w_sb;
          r_neg_rem <= w_sa;
        end
        S_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_is_div) begin
            r_hi <= w_ge ? w_sub : w_shift[31:0];
            r_lo <= {r_lo[30:0], w_ge};
          end else begin
            r_hi <= w_sum[32:1];
            r_lo <= {w_sum[0], r_lo[31:1]};
          end
        end
        S_FIN: begin
          r_done <= 1'b1;
          if (!r_is_div) begin
            HI      <= w_prod[63:32];
            LO      <= w_prod[31:0];
            DivZero <= 1'b0;
          end else if (r_b == 32'd0) begin
            HI      <= w_raw_a;
            LO      <= 32'hFFFF_FFFF;
            DivZero <= 1'b1;
          end else begin
            HI      <= w_rem;
            LO      <= w_quot;
            DivZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign Zero = (HI == 32'd0) && (LO == 32'd0);

endmodule
`default_nettype wire
